iq_frame_framer: RTL and testbench



---
 rtl/iq_frame_framer_pkg.sv | 25 ++
 rtl/iq_frame_framer_if.sv | 12 +
 rtl/iq_frame_framer_fifo.sv | 52 +++++
 rtl/iq_frame_framer.sv | 151 +++++++++++++++
 tb/tb_iq_frame_framer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/iq_frame_framer_pkg.sv
// Shared widths, defaults and sample/FIFO word types for the I/Q frame framer.
package iq_frame_framer_pkg;

  localparam int INPUT_DATA_BITWIDTH   = 32;
  localparam int IQ_HALF_W             = INPUT_DATA_BITWIDTH / 2;
  localparam int SAMPLES_PER_FRAME_DEF = 19200;
  localparam int FIFO_DEPTH_DEF        = 16;
  localparam int CNT_W_DEF             = 16;

  typedef struct packed {
    logic [IQ_HALF_W-1:0] q;
    logic [IQ_HALF_W-1:0] i;
  } iq_sample_t;

  typedef struct packed {
    logic       user;
    iq_sample_t iq;
  } fifo_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } framer_state_e;

endpackage

// File: rtl/iq_frame_framer_if.sv
// Valid/ready sample stream from the framer to the LTE processing top.
interface iq_frame_framer_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         valid;
  logic         user;
  logic         ready;

  modport master (output data, output valid, output user, input ready);
  modport slave  (input data, input valid, input user, output ready);
endinterface

// File: rtl/iq_frame_framer_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible the cycle after it is written.
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_rd     = rd_en_i && !empty_o;
  // A write into a full FIFO is legal when the head leaves on the same edge.
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/iq_frame_framer.sv
// I/Q framer: discards pre-sync samples, tags frame starts, buffers into a FWFT FIFO.
// Define FRAME_LEN_CHECK_EN to add lastFrameLen_o / lenErr_o frame-length checking.
//
//   state   | meaning
//   ST_IDLE | waiting for first sync; samples dropped silently
//   ST_RUN  | accepting samples until rst
module iq_frame_framer
  import iq_frame_framer_pkg::*;
#(
  parameter int FIFO_DEPTH        = FIFO_DEPTH_DEF,
  parameter int SAMPLES_PER_FRAME = SAMPLES_PER_FRAME_DEF,
  parameter int CNT_W             = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           syncTo10ms_i,
  input  logic [INPUT_DATA_BITWIDTH-1:0] inData_i,
  input  logic                           inValid_i,
  input  logic                           clrStatus_i,
  iq_frame_framer_if.master              out_if,
  output logic                           running_o,
  output logic                           overflow_o,
  output logic [CNT_W-1:0]               frameCnt_o
`ifdef FRAME_LEN_CHECK_EN
  ,
  output logic [CNT_W-1:0]               lastFrameLen_o,
  output logic                           lenErr_o
`endif
);
  localparam int FW = $bits(fifo_word_t);

  framer_state_e    state_q, state_d;
  logic             arm_q, arm_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       run_eff;
  logic       tag;
  logic       accept;
  logic       drop;
  logic       fifo_rd;
  logic       fifo_full;
  logic       fifo_empty;
  fifo_word_t wr_word;
  fifo_word_t head_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    drop    = 1'b0;
    fifo_rd = !fifo_empty && out_if.ready;
    // The sync cycle itself already accepts, so the IDLE->RUN sample gets tagged.
    run_eff = (state_q == ST_RUN) || syncTo10ms_i;
    tag     = arm_q || syncTo10ms_i;

    if (state_q == ST_IDLE && syncTo10ms_i) state_d = ST_RUN;

    if (run_eff && inValid_i) begin
      if (!fifo_full || fifo_rd) accept = 1'b1;
      else                       drop   = 1'b1;
    end

    arm_d = accept ? 1'b0 : tag;

    if (syncTo10ms_i)                  cnt_d = accept ? CNT_W'(1) : '0;
    else if (accept && cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);

    if (drop)             ovf_d = 1'b1;
    else if (clrStatus_i) ovf_d = 1'b0;

    wr_word      = '0;
    wr_word.user = tag;
    wr_word.iq   = iq_sample_t'(inData_i);
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_data_i (wr_word),
    .rd_en_i   (fifo_rd),
    .rd_data_o (head_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Head is masked while empty so stale RAM contents never reach the outputs.
  assign out_if.valid = !fifo_empty;
  assign out_if.data  = fifo_empty ? '0 : head_word.iq;
  assign out_if.user  = !fifo_empty && head_word.user;
  assign running_o    = (state_q == ST_RUN);
  assign overflow_o   = ovf_q;
  assign frameCnt_o   = cnt_q;

`ifdef FRAME_LEN_CHECK_EN
  localparam logic [CNT_W-1:0] SPF_C = CNT_W'(SAMPLES_PER_FRAME);

  logic [CNT_W-1:0] last_len_q, last_len_d;
  logic             len_err_q, len_err_d;
  logic             len_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_len_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      last_len_q <= last_len_d;
      len_err_q  <= len_err_d;
    end
  end

  always_comb begin
    last_len_d = last_len_q;
    len_set    = 1'b0;
    if (syncTo10ms_i && state_q == ST_RUN) begin
      last_len_d = cnt_q;
      len_set    = (cnt_q != SPF_C);
    end
    // Overrun is flagged as soon as the frame grows past its nominal length.
    if (accept && !syncTo10ms_i && cnt_q == SPF_C) len_set = 1'b1;

    if (len_set)          len_err_d = 1'b1;
    else if (clrStatus_i) len_err_d = 1'b0;
    else                  len_err_d = len_err_q;
  end

  assign lastFrameLen_o = last_len_q;
  assign lenErr_o       = len_err_q;
`endif

endmodule

// File: tb/tb_iq_frame_framer.sv
// Directed bench for iq_frame_framer: vector table plus backpressure, full, reset and frame-length sequences.
module tb_iq_frame_framer;
  import iq_frame_framer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_i = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        clr = 1'b0;
  logic        running;
  logic        overflow;
  logic [15:0] frame_cnt;
`ifdef FRAME_LEN_CHECK_EN
  logic [15:0] last_len;
  logic        len_err;
`endif

  int checks   = 0;
  int failures = 0;

  iq_frame_framer_if #(.W(32)) out_if ();

  always #5 clk = ~clk;

  iq_frame_framer #(
    .FIFO_DEPTH        (16),
    .SAMPLES_PER_FRAME (10),
    .CNT_W             (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .syncTo10ms_i   (sync_i),
    .inData_i       (in_data),
    .inValid_i      (in_valid),
    .clrStatus_i    (clr),
    .out_if         (out_if.master),
    .running_o      (running),
    .overflow_o     (overflow),
    .frameCnt_o     (frame_cnt)
`ifdef FRAME_LEN_CHECK_EN
    ,
    .lastFrameLen_o (last_len),
    .lenErr_o       (len_err)
`endif
  );

  typedef struct {
    logic        sync;
    logic        valid;
    logic        ready;
    logic        clr;
    logic [31:0] data;
    logic        e_valid;
    logic        e_user;
    logic        e_run;
    logic        e_ovf;
    logic [31:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] d, input logic r, input logic c);
    sync_i       = s;
    in_valid     = v;
    in_data      = d;
    out_if.ready = r;
    clr          = c;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10 + i, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0001_0002, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0001_0002, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA_0003, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA_0003, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hBBBB_0004, 1'b1, 1'b0, 1'b1, 1'b0, 32'hBBBB_0004, 16'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         16'd3};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         16'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 16'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         16'd1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         16'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         16'd0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0001, 1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFE_0001, 16'd1};

    do_reset();
    chk("rst_valid", 32'(out_if.valid), 32'd0);
    chk("rst_data", out_if.data, 32'd0);
    chk("rst_user", 32'(out_if.user), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);

    // Table: pre-sync discard, coincident-sync tag, sync-only arm, double sync.
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].sync, vecs[v].valid, vecs[v].data, vecs[v].ready, vecs[v].clr);
      tick();
      chk($sformatf("vec%0d_valid", v), 32'(out_if.valid), 32'(vecs[v].e_valid));
      chk($sformatf("vec%0d_data", v), out_if.data, vecs[v].e_data);
      chk($sformatf("vec%0d_user", v), 32'(out_if.user), 32'(vecs[v].e_user));
      chk($sformatf("vec%0d_running", v), 32'(running), 32'(vecs[v].e_run));
      chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(vecs[v].e_ovf));
      chk($sformatf("vec%0d_cnt", v), 32'(frame_cnt), 32'(vecs[v].e_cnt));
    end

    // Backpressure and overflow: 20 samples into a 16-deep FIFO.
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 32'h100 + k, 1'b0, 1'b0);
      tick();
      chk($sformatf("bp_hold_data%0d", k), out_if.data, 32'h100);
      chk($sformatf("bp_hold_user%0d", k), 32'(out_if.user), 32'd1);
      chk($sformatf("bp_ovf%0d", k), 32'(overflow), (k >= 16) ? 32'd1 : 32'd0);
    end
    chk("bp_cnt", 32'(frame_cnt), 32'd16);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("bp_drain_valid%0d", k), 32'(out_if.valid), 32'd1);
      chk($sformatf("bp_drain_data%0d", k), out_if.data, 32'h100 + k);
      chk($sformatf("bp_drain_user%0d", k), 32'(out_if.user), (k == 0) ? 32'd1 : 32'd0);
      tick();
    end
    chk("bp_empty", 32'(out_if.valid), 32'd0);

    // Full FIFO with simultaneous read and write: no drops, level stays at 16.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 32'h200 + k, 1'b0, 1'b0);
      tick();
    end
    chk("full_ovf0", 32'(overflow), 32'd0);
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b1, 32'h300 + j, 1'b1, 1'b0);
      tick();
      chk($sformatf("full_rw_ovf%0d", j), 32'(overflow), 32'd0);
      chk($sformatf("full_rw_data%0d", j), out_if.data, 32'h200 + j + 1);
    end
    chk("full_cnt", 32'(frame_cnt), 32'd42);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("full_drain_valid%0d", k), 32'(out_if.valid), 32'd1);
      chk($sformatf("full_drain_data%0d", k), out_if.data, (k < 6) ? 32'h20A + k : 32'h300 + (k - 6));
      tick();
    end
    chk("full_drain_empty", 32'(out_if.valid), 32'd0);

    // Reset with samples buffered, then pre-sync discard again.
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b1, 32'h400 + k, 1'b0, 1'b0);
      tick();
    end
    chk("mid_valid_pre", 32'(out_if.valid), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 32'(out_if.valid), 32'd0);
    chk("mid_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_running", 32'(running), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'h500 + k, 1'b1, 1'b0);
      tick();
      chk($sformatf("mid_discard_valid%0d", k), 32'(out_if.valid), 32'd0);
      chk($sformatf("mid_discard_cnt%0d", k), 32'(frame_cnt), 32'd0);
    end
    drive(1'b1, 1'b1, 32'h600, 1'b1, 1'b0);
    tick();
    chk("mid_resync_data", out_if.data, 32'h600);
    chk("mid_resync_user", 32'(out_if.user), 32'd1);

`ifdef FRAME_LEN_CHECK_EN
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 32'h700 + k, 1'b1, 1'b0);
      tick();
    end
    chk("len_cnt10", 32'(frame_cnt), 32'd10);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("len_last10", 32'(last_len), 32'd10);
    chk("len_err0", 32'(len_err), 32'd0);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b1, 32'h800 + k, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("len_last9", 32'(last_len), 32'd9);
    chk("len_err9", 32'(len_err), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    chk("len_clr", 32'(len_err), 32'd0);
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, 1'b1, 32'h900 + k, 1'b1, 1'b0);
      tick();
      chk($sformatf("len_over%0d", k), 32'(len_err), (k == 10) ? 32'd1 : 32'd0);
    end
`endif

    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
